dsp_i2s_tx: RTL and testbench

Serial audio transmitter that takes the DSP's parallel signed stereo samples, one pair per 64-clock sample period, and drives a standard Philips I2S link (BCLK, LRCK, SDATA) to an external DAC. It sits directly downstream of the DSP's `dac_out_l`/`dac_out_r` latch and shares its clock. It provides single-sample buffering, a free-running frame counter, and sticky overrun/underrun status.

---
 rtl/dsp_audio_pkg.sv | 29 ++
 rtl/dsp_i2s_tx.sv | 131 +++++++++++++
 tb/tb_dsp_i2s_tx.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_audio_pkg.sv
// Shared audio definitions for the DSP mixer and the I2S transmitter:
// sample width, frame geometry, the stereo pair type and the I2S
// word-select decode for a given frame phase.
package dsp_audio_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int SLOT_BITS    = SAMPLE_W;
    localparam int FRAME_BITS   = 2 * SLOT_BITS;
    localparam int FRAME_CLOCKS = 4 * SAMPLE_W;
    localparam int PHASE_W      = $clog2(FRAME_CLOCKS);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    // Word select is high for the right slot, but it leads the data by one
    // bit period, so it rises at the last left bit and falls at the last
    // right bit.
    function automatic logic ws_for_phase(input logic [PHASE_W-1:0] p);
        logic [PHASE_W-2:0] b;
        b = p[PHASE_W-1:1];
        return (b >= (PHASE_W-1)'(SLOT_BITS - 1)) &&
               (b <= (PHASE_W-1)'(2 * SLOT_BITS - 2));
    endfunction

endpackage

// File: rtl/dsp_i2s_tx.sv
// Philips I2S transmitter: one stereo pair per 64-clock frame, BCLK at
// clock/2, single-pair holding buffer and sticky overrun/underrun flags.
// Build option DSP_I2S_UNDERRUN_MUTE_EN: when defined an underrun frame is
// sent as zeros; otherwise the last pair is sent again.
module dsp_i2s_tx
    import dsp_audio_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] sample_l,
    input  logic signed [SAMPLE_W-1:0] sample_r,
    input  logic                       sample_valid,
    input  logic                       status_clear,
    output logic                       i2s_bclk,
    output logic                       i2s_lrck,
    output logic                       i2s_sdata,
    output logic                       underrun,
    output logic                       overrun
);

    localparam logic [PHASE_W-1:0] P_LAST = PHASE_W'(FRAME_CLOCKS - 1);

    logic [PHASE_W-1:0]    p;
    logic [PHASE_W-1:0]    p_nxt;
    stereo_t               hold;
    logic                  pending;
    logic                  armed;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] shreg_nxt;
    logic [FRAME_BITS-1:0] frame_src;
    logic                  load_edge;
    logic                  underrun_evt;
    logic                  overrun_evt;

    assign p_nxt     = p + PHASE_W'(1);
    assign load_edge = (p == P_LAST);

    // A load with nothing new is only an underrun once traffic has started.
    assign underrun_evt = load_edge && !pending && !sample_valid && armed;
    // Replacing a held pair is an overrun, except at the load edge where the
    // new pair goes straight to the shifter instead.
    assign overrun_evt  = sample_valid && pending && !load_edge;

    // Select what the next frame carries: bypass, held pair, or fill.
    always_comb begin
        frame_src = '0;
        if (sample_valid) begin
            frame_src = {sample_l, sample_r};
        end else if (pending) begin
            frame_src = hold;
        end else if (armed) begin
`ifdef DSP_I2S_UNDERRUN_MUTE_EN
            frame_src = '0;
`else
            frame_src = hold;
`endif
        end
    end

    // Shifter loads at the frame boundary and advances when BCLK falls.
    always_comb begin
        shreg_nxt = shreg;
        if (load_edge) begin
            shreg_nxt = frame_src;
        end else if (p[0]) begin
            shreg_nxt = {shreg[FRAME_BITS-2:0], 1'b0};
        end
    end

    // Free-running frame phase counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p <= '0;
        end else begin
            p <= p_nxt;
        end
    end

    // Holding register, pending and armed bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold    <= '0;
            pending <= 1'b0;
            armed   <= 1'b0;
        end else begin
            if (sample_valid) begin
                hold  <= {sample_l, sample_r};
                armed <= 1'b1;
            end
            if (load_edge) begin
                pending <= 1'b0;
            end else if (sample_valid) begin
                pending <= 1'b1;
            end
        end
    end

    // Frame shift register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
        end else begin
            shreg <= shreg_nxt;
        end
    end

    // Registered link outputs, computed for the phase being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i2s_bclk  <= 1'b0;
            i2s_lrck  <= 1'b0;
            i2s_sdata <= 1'b0;
        end else begin
            i2s_bclk  <= p_nxt[0];
            i2s_lrck  <= ws_for_phase(p_nxt);
            i2s_sdata <= shreg_nxt[FRAME_BITS-1];
        end
    end

    // Sticky status flags; a set event beats a simultaneous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            underrun <= underrun_evt || (underrun && !status_clear);
            overrun  <= overrun_evt  || (overrun  && !status_clear);
        end
    end

endmodule

// File: tb/tb_dsp_i2s_tx.sv
// Self-checking bench for dsp_i2s_tx: a monitor deserialises each frame
// from the link and checks it against a scoreboard of expected frames
// queued by the stimulus; flags and status are checked inline.
module tb_dsp_i2s_tx;

    localparam int CLK_HALF = 5;

    logic        clock;
    logic        rst_n;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        status_clear;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_sdata;
    logic        underrun;
    logic        overrun;

    typedef struct {
        int          idx;
        logic [31:0] word;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests;
    int          n_fail;
    logic [5:0]  tb_p;
    int          tb_fr;
    logic [31:0] ur_word;

    dsp_i2s_tx dut (
        .clock        (clock),
        .reset        (rst_n),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .status_clear (status_clear),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_sdata    (i2s_sdata),
        .underrun     (underrun),
        .overrun      (overrun)
    );

    initial clock = 1'b0;
    always #CLK_HALF clock = ~clock;

    // Bench reference for the frame phase and frame index.
    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tb_p  <= '0;
            tb_fr <= 0;
        end else begin
            tb_p <= tb_p + 6'd1;
            if (tb_p == 6'd63) tb_fr <= tb_fr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (frame %0d p %0d)", name, act, exp, tb_fr, tb_p);
        end
    endtask

    function automatic logic exp_ws(input logic [5:0] p);
        int b;
        b = int'(p[5:1]);
        return (b >= 15) && (b <= 30);
    endfunction

    task automatic push(input int idx, input logic [31:0] word);
        exp_t e;
        e.idx  = idx;
        e.word = word;
        sb_q.push_back(e);
    endtask

    // Returns at the negedge just before the posedge where p == pt in frame ft.
    task automatic wait_at(input int ft, input int pt);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
            if (n > 20000) begin
                $display("FAIL wait_at: timeout waiting for frame %0d p %0d", ft, pt);
                $fatal(1, "timeout");
            end
        end while (!(tb_fr == ft && int'(tb_p) == pt));
    endtask

    task automatic strobe(input logic [15:0] l, input logic [15:0] r);
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
    endtask

    task automatic clear_pulse();
        status_clear = 1'b1;
        @(negedge clock);
        status_clear = 1'b0;
    endtask

    // Monitor: check BCLK/WS every cycle, collect bits, compare each frame.
    initial begin
        logic [31:0] word;
        int          hdr_err;
        exp_t        e;
        word    = '0;
        hdr_err = 0;
        forever begin
            @(negedge clock);
            if (!rst_n) begin
                word    = '0;
                hdr_err = 0;
            end else begin
                if (i2s_bclk !== tb_p[0] || i2s_lrck !== exp_ws(tb_p)) hdr_err++;
                if (tb_p[0]) word[31 - int'(tb_p[5:1])] = i2s_sdata;
                if (tb_p == 6'd63) begin
                    chk("bclk_lrck_errs", hdr_err, 0);
                    hdr_err = 0;
                    while (sb_q.size() > 0 && sb_q[0].idx < tb_fr) begin
                        e = sb_q.pop_front();
                        chk("frame_missed", e.idx, tb_fr);
                    end
                    if (sb_q.size() > 0 && sb_q[0].idx == tb_fr) begin
                        e = sb_q.pop_front();
                        chk("frame_data", word, e.word);
                    end
                    word = '0;
                end
            end
        end
    end

    initial begin
        #(CLK_HALF * 2 * 30000);
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        sample_l     = '0;
        sample_r     = '0;
        sample_valid = 1'b0;
        status_clear = 1'b0;
`ifdef DSP_I2S_UNDERRUN_MUTE_EN
        ur_word = 32'h0000_0000;
`else
        ur_word = 32'h2222_2222;
`endif

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_bclk", {31'd0, i2s_bclk}, 0);
        chk("rst_lrck", {31'd0, i2s_lrck}, 0);
        chk("rst_sdata", {31'd0, i2s_sdata}, 0);
        chk("rst_underrun", {31'd0, underrun}, 0);
        chk("rst_overrun", {31'd0, overrun}, 0);
        chk("rst_pending", {31'd0, dut.pending}, 0);
        rst_n = 1'b1;
        push(0, 32'h0);

        // Bypass strobe on the load edge
        wait_at(0, 63);
        strobe(16'h8001, 16'h7FFE);
        push(1, 32'h8001_7FFE);
        wait_at(1, 5);
        chk("t1_underrun", {31'd0, underrun}, 0);
        chk("t1_overrun", {31'd0, overrun}, 0);

        // Mid-frame strobe goes to the next frame
        wait_at(1, 20);
        strobe(16'hA5A5, 16'h5A5A);
        push(2, 32'hA5A5_5A5A);
        chk("t2_pending_set", {31'd0, dut.pending}, 1);
        wait_at(1, 63);
        chk("t2_pending_before", {31'd0, dut.pending}, 1);
        @(negedge clock);
        chk("t2_pending_after", {31'd0, dut.pending}, 0);

        // Overrun: the newer sample wins
        wait_at(2, 10);
        strobe(16'h1111, 16'h1111);
        wait_at(2, 30);
        strobe(16'h2222, 16'h2222);
        push(3, 32'h2222_2222);
        chk("t3_overrun", {31'd0, overrun}, 1);
        wait_at(2, 40);
        clear_pulse();
        chk("t3_overrun_clr", {31'd0, overrun}, 0);

        // Underrun after one frame without a strobe
        wait_at(3, 63);
        chk("t4_underrun_pre", {31'd0, underrun}, 0);
        @(negedge clock);
        chk("t4_underrun", {31'd0, underrun}, 1);
        push(4, ur_word);
        push(5, ur_word);

        // Clear collides with an overrun: the set wins
        wait_at(5, 10);
        clear_pulse();
        chk("t5_underrun_clr", {31'd0, underrun}, 0);
        chk("t5_overrun_clr", {31'd0, overrun}, 0);
        wait_at(5, 20);
        strobe(16'h1234, 16'h5678);
        wait_at(5, 30);
        status_clear = 1'b1;
        strobe(16'hCAFE, 16'hBEEF);
        status_clear = 1'b0;
        push(6, 32'hCAFE_BEEF);
        chk("t5_overrun_wins", {31'd0, overrun}, 1);
        wait_at(5, 40);
        clear_pulse();
        chk("t5_overrun_clr2", {31'd0, overrun}, 0);
        wait_at(6, 63);
        @(negedge clock);
        chk("t5_underrun_f7", {31'd0, underrun}, 1);

        // Reset mid-frame at p=37
        wait_at(7, 37);
        rst_n = 1'b0;
        #1;
        chk("t6_bclk", {31'd0, i2s_bclk}, 0);
        chk("t6_lrck", {31'd0, i2s_lrck}, 0);
        chk("t6_sdata", {31'd0, i2s_sdata}, 0);
        chk("t6_underrun", {31'd0, underrun}, 0);
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        push(0, 32'h0);
        push(1, 32'h0);
        wait_at(2, 5);
        chk("t6_no_underrun", {31'd0, underrun}, 0);
        strobe(16'h1357, 16'h2468);
        push(3, 32'h1357_2468);
        wait_at(2, 63);
        @(negedge clock);
        chk("t6_no_underrun2", {31'd0, underrun}, 0);
        wait_at(3, 63);
        @(negedge clock);
        chk("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
